// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reordering stage behind the fft core.
// Ping-pong frame buffer: one bank fills while the other drains.
module fft_bitrev_reorder #(
   parameter int LOG2N = 8,
   parameter int W     = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] realin,
   input  logic [W-1:0] imagin,
   input  logic         startin,
   output logic [W-1:0] realout,
   output logic [W-1:0] imagout,
   output logic         startout
);

   localparam int N = 1 << LOG2N;

   typedef enum logic {W_IDLE, W_FILL} wstate_t;
   typedef enum logic {R_IDLE, R_RUN} rstate_t;

   logic [2*W-1:0] mem [2*N];

   wstate_t          wstate;
   rstate_t          rstate;
   logic [LOG2N-1:0] wcnt;
   logic [LOG2N-1:0] rcnt;
   logic             wsel;
   logic             rsel;
   logic             rd_pending;

   logic             we;
   logic [LOG2N-1:0] waddr;

   logic [2*W-1:0]   rdata;
   logic             rvalid;
   logic             rstart;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   // startin always wins: it opens a new frame at address 0
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      if (!reset) begin
         if (startin) begin
            we    = 1'b1;
            waddr = '0;
         end else if (wstate == W_FILL) begin
            we    = 1'b1;
            waddr = bitrev(wcnt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[{wsel, waddr}] <= {realin, imagin};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wstate     <= W_IDLE;
         wcnt       <= '0;
         wsel       <= 1'b0;
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= 1'b0;
         if (startin) begin
            wstate <= W_FILL;
            wcnt   <= LOG2N'(1);
         end else if (wstate == W_FILL) begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) begin
               wstate     <= W_IDLE;
               wsel       <= ~wsel;
               rd_pending <= 1'b1;
            end
         end
      end
   end

   // the bank just filled is the one wsel has toggled away from
   always_ff @(posedge clk) begin
      if (reset) begin
         rstate <= R_IDLE;
         rcnt   <= '0;
         rsel   <= 1'b0;
      end else if (rd_pending) begin
         rstate <= R_RUN;
         rcnt   <= '0;
         rsel   <= ~wsel;
      end else if (rstate == R_RUN) begin
         rcnt <= rcnt + 1'b1;
         if (&rcnt) rstate <= R_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rstate == R_RUN) rdata <= mem[{rsel, rcnt}];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid <= 1'b0;
         rstart <= 1'b0;
      end else begin
         rvalid <= (rstate == R_RUN);
         rstart <= (rstate == R_RUN) && (rcnt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !rvalid) begin
         realout  <= '0;
         imagout  <= '0;
         startout <= 1'b0;
      end else begin
         realout  <= rdata[2*W-1:W];
         imagout  <= rdata[W-1:0];
         startout <= rstart;
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized scoreboard bench for fft_bitrev_reorder.
// Frames are reordered by an array model; a negedge monitor checks every cycle.
module tb_fft_bitrev_reorder;

   localparam int LOG2N = 8;
   localparam int W     = 20;
   localparam int N     = 1 << LOG2N;

   typedef struct {
      int         cyc;
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic       st;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] realin = '0;
   logic [W-1:0] imagin = '0;
   logic         startin = 1'b0;
   logic [W-1:0] realout;
   logic [W-1:0] imagout;
   logic         startout;

   int   edges = 0;
   int   checks = 0;
   int   errors = 0;
   int   starts_seen = 0;
   bit   mon_en = 1'b0;

   exp_t         q[$];
   logic [W-1:0] cur_re[$];
   logic [W-1:0] cur_im[$];

   fft_bitrev_reorder #(.LOG2N(LOG2N), .W(W)) dut (
      .clk(clk),
      .reset(reset),
      .realin(realin),
      .imagin(imagin),
      .startin(startin),
      .realout(realout),
      .imagout(imagout),
      .startout(startout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   function automatic int bitrev(input int a);
      int r = 0;
      for (int i = 0; i < LOG2N; i++)
         if (a & (1 << i)) r |= 1 << (LOG2N - 1 - i);
      return r;
   endfunction

   // one input cycle; the model collects the frame and, once complete,
   // schedules natural-order outputs 3+k edges after the capturing edge
   task automatic drive(input logic st, input logic [W-1:0] re,
                        input logic [W-1:0] im);
      int e;
      exp_t x;
      startin = st;
      realin  = re;
      imagin  = im;
      @(posedge clk);
      #1;
      e = edges;
      if (st) begin
         cur_re.delete();
         cur_im.delete();
      end
      if (st || cur_re.size() > 0) begin
         cur_re.push_back(re);
         cur_im.push_back(im);
      end
      if (cur_re.size() == N) begin
         for (int k = 0; k < N; k++) begin
            x.cyc = e + 3 + k;
            x.re  = cur_re[bitrev(k)];
            x.im  = cur_im[bitrev(k)];
            x.st  = (k == 0);
            q.push_back(x);
         end
         cur_re.delete();
         cur_im.delete();
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), W'($urandom));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         reset   = 1'b1;
         startin = 1'b0;
         @(posedge clk);
         #1;
         while (q.size() > 0 && q[$].cyc >= edges) void'(q.pop_back());
         cur_re.delete();
         cur_im.delete();
      end
      reset = 1'b0;
   endtask

   task automatic frame_rand();
      for (int p = 0; p < N; p++)
         drive(p == 0, W'($urandom), W'($urandom));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t x;
         while (q.size() > 0 && q[0].cyc < edges) begin
            x = q.pop_front();
            errors++;
            checks++;
            $display("FAIL missed_output cyc=%0d expected re=%0h im=%0h",
                     x.cyc, x.re, x.im);
         end
         x.cyc = edges;
         x.re  = '0;
         x.im  = '0;
         x.st  = 1'b0;
         if (q.size() > 0 && q[0].cyc == edges) x = q.pop_front();
         checks++;
         if (startout === 1'b1) starts_seen++;
         if (realout !== x.re || imagout !== x.im || startout !== x.st) begin
            errors++;
            $display("FAIL out cyc=%0d got re=%0h im=%0h st=%b want re=%0h im=%0h st=%b",
                     edges, realout, imagout, startout, x.re, x.im, x.st);
         end
      end
   end

   initial begin
      int s0;
      do_reset(3);
      mon_en = 1'b1;

      // idle with random data: outputs stay zero
      idle(500);

      // single frame, real=k imag=-k after reordering
      s0 = starts_seen;
      for (int p = 0; p < N; p++)
         drive(p == 0, W'(bitrev(p)), -W'(bitrev(p)));
      idle(300);
      checks++;
      if (starts_seen - s0 != 1) begin
         errors++;
         $display("FAIL single_start_count got=%0d want=1", starts_seen - s0);
      end

      // three back-to-back frames
      s0 = starts_seen;
      for (int f = 0; f < 3; f++)
         for (int p = 0; p < N; p++)
            drive(p == 0, W'(f * 1000 + bitrev(p)), W'($urandom));
      idle(300);
      checks++;
      if (starts_seen - s0 != 3) begin
         errors++;
         $display("FAIL b2b_start_count got=%0d want=3", starts_seen - s0);
      end

      // truncated frame restarted at position 100
      for (int p = 0; p < 100; p++)
         drive(p == 0, W'($urandom), W'($urandom));
      frame_rand();
      idle(300);

      // reset while output index 50 is showing
      frame_rand();
      idle(53);
      do_reset(1);
      idle(20);
      frame_rand();
      idle(300);

      // two frames with a 37-cycle gap
      s0 = starts_seen;
      frame_rand();
      idle(37);
      frame_rand();
      idle(300);
      checks++;
      if (starts_seen - s0 != 2) begin
         errors++;
         $display("FAIL gap_start_count got=%0d want=2", starts_seen - s0);
      end

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drained got=%0d pending want=0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reordering stage placed directly downstream of the fft core.
- The fft core emits each 256-point frame in bit-reversed index order. This block buffers one frame and re-emits it in natural order 0..N-1.
- It uses the same streaming interface on both sides: 20-bit signed real/imag samples, one sample per clock, and a start pulse on the first sample of a frame.
- Ping-pong buffering sustains back-to-back frames with no stall.

Parameters:
- LOG2N, 8, log2 of frame length (N = 256).
- W, 20, width of each real/imag sample, two's complement.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- realin  input  W  real sample from fft core.
- imagin  input  W  imaginary sample from fft core.
- startin  input  1  high on the cycle carrying bit-reversed sample 0 of a frame.
- realout  output  W  real sample, natural order, registered.
- imagout  output  W  imaginary sample, natural order, registered.
- startout  output  1  high on the cycle carrying natural-order sample 0, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. When reset=1 at an edge:
  - write and read counters clear;
  - bank select clears to bank 0;
  - wr_active, rd_active and rd_pending clear;
  - realout, imagout and startout go to 0.
  - RAM contents are not cleared. A frame in progress at reset is abandoned and never emitted.
- Storage: two banks, each N x 2W, with registered (1-cycle) read. One bank is written while the other is read.
- Frame definition: a frame is the startin cycle plus the next N-1 consecutive cycles. No valid gaps are allowed inside a frame. Idle cycles may occur between frames.
- Write FSM, states W_IDLE and W_FILL:
  - W_IDLE: on an edge with startin=1, write {realin,imagin} to wbank[0], set wcnt=1, go to W_FILL.
  - W_FILL: each edge writes wbank[bitrev(wcnt)] and increments wcnt.
  - When wcnt = N-1 is written: toggle the bank select, pulse rd_pending, return to W_IDLE.
  - startin=1 while in W_FILL restarts the frame in the same bank: the sample is written to address 0 and wcnt=1. The partial frame is discarded.
  - bitrev() reverses the LOG2N address bits.
- Read FSM, states R_IDLE and R_RUN:
  - rd_pending starts R_RUN with rcnt=0 on the bank just filled.
  - The RAM read address is natural rcnt, incrementing each cycle until it reaches N-1, then R_IDLE.
  - A new rd_pending cannot arrive before the current read finishes, because a fill takes at least N cycles. No overflow logic is required.
- Latency: let edge E be the edge that captures the last input sample.
  - Outputs for natural index 0 appear after edge E+3 and hold until E+4.
  - Index k appears after edge E+3+k.
- startout is 1 only for index 0 and 0 for indices 1..N-1.
- When no frame is being read, realout = imagout = 0 and startout = 0. Outputs are never X after reset.
- Samples pass through unchanged: no arithmetic, rounding or saturation.
- Back-to-back input frames (startin every N cycles) produce back-to-back output frames with constant latency.
- All outputs are driven from flops, so they are stable for the full cycle and hold after the clock edge.

Test Plan:
1. Reset for 3 cycles, then hold startin=0 with random data for 500 cycles → outputs stay 0, startout never 1.
2. Single frame: input sample at position p is real=bitrev(p), imag=-bitrev(p) → startout high once, 3 edges after the last input. Output k is real=k, imag=-k for k = 0..255, then outputs return to 0.
3. Three frames back-to-back, with frame f real=f*1000+k for natural index k → 768 contiguous outputs in natural order, startout at output indices 0, 256 and 512, constant latency.
4. Assert startin at input position 100 of a frame, then send a full 256-sample frame → only the second frame is emitted, correctly reordered. No output from the truncated frame.
5. Assert reset at output index 50 of a frame → outputs are 0 on the next cycle and no further samples from that frame appear. A new frame after reset is emitted correctly.
6. Two frames separated by a 37-cycle idle gap → each emitted in natural order, outputs 0 in between, startout exactly twice.
